game_pattern_gen: RTL and testbench
===================================

Name: game_pattern_gen

Overview:
- Writer side of the memory-game pattern interface.
- Generates a pseudo-random 8-note melody word for the game module and loads it with a one-cycle `write_enable` strobe.
- Then fires `game_start` and waits for `game_end` before it accepts another round.
- Sits between the board's "new game" button and the game module's `data_in` / `write_enable` / `game_start` inputs.

Parameters:
- NOTE_COUNT, 8, notes placed in the word (1..8); unused fields are 0.
- LFSR_TAPS, 16'hB400, Galois feedback mask for the 16-bit LFSR.
- RESET_SEED, 16'hACE1, LFSR value after reset.
- START_DELAY, 4, idle cycles between the `write_enable` pulse and the `game_start` pulse (1..15).
- NO_REPEAT, 1, when 1 adjacent notes must differ.
- MAX_REJECT, 63, rejected draws allowed per note before forced fallback.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- new_game  in  1  level/pulse request for a new round; sampled only in IDLE.
- seed_load  in  1  loads `seed` into the LFSR; honoured only in IDLE.
- seed  in  16  seed value.
- game_end  in  1  level from the game module; high means the round is finished.
- data_out  out  32  pattern word; drive into the game module's `data_in`.
- write_enable  out  1  one-cycle strobe; `data_out` is valid in that cycle.
- game_start  out  1  one-cycle strobe.
- busy  out  1  high in every state except IDLE.
- round_count  out  8  completed rounds, saturating at 255.

Behaviour:
- Reset (synchronous, active-high; the only reset):
  - state=IDLE, lfsr=RESET_SEED, data_out=0, write_enable=0, game_start=0, busy=0, round_count=0.
  - Reset asserted in any state aborts the round immediately. No strobe is emitted in the reset cycle.
- LFSR:
  - Galois right-shift: if lsb=1, next = (lfsr>>1) ^ LFSR_TAPS, else next = lfsr>>1.
  - Advances every cycle in all states; request timing therefore adds entropy.
- Seed handling:
  - seed_load in IDLE sets lfsr=seed that cycle; seed==0 is replaced by 16'h0001.
  - seed_load has priority over new_game in the same cycle; new_game is then ignored.
- States: IDLE, GEN, WRITE, DELAY, START, WAIT_END.
- IDLE:
  - new_game=1 and seed_load=0 -> GEN.
  - Clear the working word and note index; reject counter=0.
- GEN (one draw per cycle):
  - Candidate = lfsr[2:0].
  - Reject if candidate==0.
  - Reject if NO_REPEAT=1, index>0 and candidate==previous note.
  - Accept: write the candidate into bits [4i+2:4i] with bit 4i+3=0; index+1; reject counter=0.
  - Reject: reject counter+1. On reaching MAX_REJECT, force note = (prev mod 7)+1 (prev=0 for index 0) and accept.
  - After NOTE_COUNT accepts -> WRITE. Fields i >= NOTE_COUNT stay 0.
- WRITE:
  - data_out = working word; write_enable=1 for exactly this cycle -> DELAY.
  - data_out holds until the next WRITE or reset.
- DELAY: count START_DELAY cycles -> START.
- START: game_start=1 for exactly one cycle -> WAIT_END.
- WAIT_END:
  - game_end=1 -> round_count+1 (saturating at 255) -> IDLE.
  - new_game is ignored while busy; no queuing.
- game_end already high on entry to WAIT_END: accepted the first cycle in WAIT_END. It is a level and is not edge-detected.
- Strobes never overlap, and neither fires outside its state.
- Minimum latency from new_game to write_enable is NOTE_COUNT+1 cycles.

Test Plan:
- Reset, then new_game for 1 cycle:
  - write_enable pulses once.
  - Every field [4i+2:4i] of data_out is in 1..7 and every bit 4i+3 is 0.
  - No two adjacent fields are equal.
  - game_start pulses exactly START_DELAY+1 cycles after write_enable; busy=1.
- seed_load seed=16'h1234, then new_game at a fixed cycle offset; repeat the identical sequence after reset:
  - Both data_out words are identical.
  - seed=0 behaves identically to seed=16'h0001.
- new_game held high through the whole round, game_end=0:
  - Exactly one write_enable and one game_start.
  - Block stays in WAIT_END and round_count stays 0.
- Assert game_end=1 for 1 cycle in WAIT_END:
  - round_count=1 and busy=0 next cycle.
  - 256 rounds saturate round_count at 255.
- Reset mid-GEN and mid-DELAY:
  - Outputs return to reset values next cycle.
  - No write_enable or game_start appears until a new new_game.
- NOTE_COUNT=3 build:
  - data_out[31:12]==0.
  - write_enable arrives no earlier than 4 cycles after new_game.

Source files
------------

// File: rtl/game_pattern_gen.sv
// Writer side of the memory-game pattern interface: draws an LFSR melody,
// loads it into the game module, starts the round and waits for its end.
module game_pattern_gen #(
  parameter int          NOTE_COUNT  = 8,
  parameter logic [15:0] LFSR_TAPS   = 16'hB400,
  parameter logic [15:0] RESET_SEED  = 16'hACE1,
  parameter int          START_DELAY = 4,
  parameter bit          NO_REPEAT   = 1'b1,
  parameter int          MAX_REJECT  = 63
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        new_game,
  input  logic        seed_load,
  input  logic [15:0] seed,
  input  logic        game_end,
  output logic [31:0] data_out,
  output logic        write_enable,
  output logic        game_start,
  output logic        busy,
  output logic [7:0]  round_count
);

  localparam int         REJ_W     = $clog2(MAX_REJECT + 1);
  localparam logic [2:0] LAST_IDX  = 3'(NOTE_COUNT - 1);
  localparam logic [3:0] LAST_WAIT = 4'(START_DELAY - 1);

  typedef enum logic [2:0] {
    IDLE,
    GEN,
    WRITE,
    DELAY,
    START,
    WAIT_END
  } state_t;

  state_t             state;
  logic [15:0]        lfsr;
  logic [15:0]        lfsr_next;
  logic [31:0]        work_word;
  logic [31:0]        next_word;
  logic [2:0]         note_idx;
  logic [REJ_W-1:0]   reject_cnt;
  logic [3:0]         delay_cnt;
  logic [2:0]         prev_note;
  logic [2:0]         candidate;
  logic [2:0]         forced_note;
  logic [2:0]         new_note;
  logic               cand_bad;
  logic               last_reject;
  logic               accept;

  // A draw is rejected for a silent note or an immediate repeat; after too
  // many rejections the next note in the 1..7 cycle is forced so GEN always ends.
  always_comb begin
    lfsr_next   = lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
    candidate   = lfsr[2:0];
    cand_bad    = (candidate == 3'd0) ||
                  (NO_REPEAT && (note_idx != 3'd0) && (candidate == prev_note));
    last_reject = (reject_cnt == REJ_W'(MAX_REJECT - 1));
    forced_note = (prev_note == 3'd7) ? 3'd1 : prev_note + 3'd1;
    new_note    = cand_bad ? forced_note : candidate;
    accept      = !cand_bad || last_reject;
    next_word   = work_word;
    next_word[4*note_idx +: 4] = {1'b0, new_note};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      lfsr         <= RESET_SEED;
      data_out     <= 32'd0;
      write_enable <= 1'b0;
      game_start   <= 1'b0;
      busy         <= 1'b0;
      round_count  <= 8'd0;
      work_word    <= 32'd0;
      note_idx     <= 3'd0;
      reject_cnt   <= '0;
      delay_cnt    <= 4'd0;
      prev_note    <= 3'd0;
    end else begin
      lfsr         <= lfsr_next;
      write_enable <= 1'b0;
      game_start   <= 1'b0;
      case (state)
        IDLE: begin
          work_word  <= 32'd0;
          note_idx   <= 3'd0;
          reject_cnt <= '0;
          prev_note  <= 3'd0;
          busy       <= 1'b0;
          // A seed load wins over a simultaneous new_game request.
          if (seed_load) begin
            lfsr <= (seed == 16'd0) ? 16'h0001 : seed;
          end else if (new_game) begin
            state <= GEN;
            busy  <= 1'b1;
          end
        end
        GEN: begin
          if (accept) begin
            work_word  <= next_word;
            prev_note  <= new_note;
            reject_cnt <= '0;
            if (note_idx == LAST_IDX) begin
              state        <= WRITE;
              data_out     <= next_word;
              write_enable <= 1'b1;
            end else begin
              note_idx <= note_idx + 3'd1;
            end
          end else begin
            reject_cnt <= reject_cnt + 1'b1;
          end
        end
        WRITE: begin
          state     <= DELAY;
          delay_cnt <= 4'd0;
        end
        DELAY: begin
          if (delay_cnt == LAST_WAIT) begin
            state      <= START;
            game_start <= 1'b1;
          end else begin
            delay_cnt <= delay_cnt + 4'd1;
          end
        end
        START: begin
          state <= WAIT_END;
        end
        WAIT_END: begin
          if (game_end) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (round_count != 8'hFF) begin
              round_count <= round_count + 8'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_pattern_gen.sv
// Scoreboard bench for game_pattern_gen: a reference LFSR/melody model predicts
// each word and strobe timing; a second instance covers a 3-note build.
module tb_game_pattern_gen;

  localparam int NOTE_COUNT  = 8;
  localparam int START_DELAY = 4;

  typedef struct {
    logic [31:0] word;
    int          we_cyc;
    int          drive_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        new_game = 1'b0;
  logic        seed_load = 1'b0;
  logic [15:0] seed = 16'd0;
  logic        game_end = 1'b0;
  logic [31:0] data_out;
  logic        write_enable;
  logic        game_start;
  logic        busy;
  logic [7:0]  round_count;

  logic        new_game3 = 1'b0;
  logic        seed_load3 = 1'b0;
  logic        game_end3 = 1'b1;
  logic [31:0] data_out3;
  logic        write_enable3;
  logic        game_start3;
  logic        busy3;
  logic [7:0]  round_count3;

  int          num_checks = 0;
  int          num_errors = 0;
  int          cyc = 0;
  int          we_count = 0;
  int          gs_count = 0;
  int          gs3_count = 0;
  logic [15:0] lfsr_m;
  logic [15:0] lfsr3_m;
  exp_t        sb_q[$];
  exp_t        sb3_q[$];
  int          gs_q[$];

  game_pattern_gen dut (
    .clk(clk), .reset(reset), .new_game(new_game), .seed_load(seed_load),
    .seed(seed), .game_end(game_end), .data_out(data_out),
    .write_enable(write_enable), .game_start(game_start), .busy(busy),
    .round_count(round_count)
  );

  game_pattern_gen #(.NOTE_COUNT(3)) dut3 (
    .clk(clk), .reset(reset), .new_game(new_game3), .seed_load(seed_load3),
    .seed(seed), .game_end(game_end3), .data_out(data_out3),
    .write_enable(write_enable3), .game_start(game_start3), .busy(busy3),
    .round_count(round_count3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] step(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  // Reference LFSRs; the main seed is only ever loaded while the DUT is idle.
  always @(posedge clk) begin
    if (reset) begin
      lfsr_m  <= 16'hACE1;
      lfsr3_m <= 16'hACE1;
    end else begin
      lfsr_m  <= seed_load ? ((seed == 16'd0) ? 16'h0001 : seed) : step(lfsr_m);
      lfsr3_m <= step(lfsr3_m);
    end
  end

  function automatic void genWord(input logic [15:0] start, input int nc,
                                  output logic [31:0] w, output int cycles);
    logic [15:0] l;
    logic [2:0]  cand;
    logic [2:0]  prev;
    int          idx;
    int          rej;
    l = start; w = 32'd0; cycles = 0; idx = 0; rej = 0; prev = 3'd0;
    while (idx < nc) begin
      cycles++;
      cand = l[2:0];
      if (cand == 3'd0 || (idx > 0 && cand == prev)) begin
        rej++;
        if (rej == 63) begin
          cand = (prev == 3'd7) ? 3'd1 : prev + 3'd1;
          rej = 0;
        end else begin
          cand = 3'd0;
        end
      end else begin
        rej = 0;
      end
      if (cand != 3'd0) begin
        w[4*idx +: 3] = cand;
        prev = cand;
        idx++;
      end
      l = step(l);
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit hold);
    exp_t        e;
    logic [31:0] w;
    int          n;
    genWord(step(lfsr_m), NOTE_COUNT, w, n);
    e.word = w; e.drive_cyc = cyc; e.we_cyc = cyc + n + 1;
    sb_q.push_back(e);
    new_game = 1'b1;
    if (!hold) begin
      @(negedge clk);
      new_game = 1'b0;
    end
  endtask

  task automatic applyStimulus3();
    exp_t        e;
    logic [31:0] w;
    int          n;
    genWord(step(lfsr3_m), 3, w, n);
    e.word = w; e.drive_cyc = cyc; e.we_cyc = cyc + n + 1;
    sb3_q.push_back(e);
    new_game3 = 1'b1;
    @(negedge clk);
    new_game3 = 1'b0;
  endtask

  // which: 0 write_enable, 1 game_start, 2 busy low, 3 write_enable of dut3
  task automatic waitFor(input int which, input int budget, input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((which == 0 && write_enable) || (which == 1 && game_start) ||
          (which == 2 && !busy) || (which == 3 && write_enable3)) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) checkOutput(tag, 32'd0, 32'd1);
  endtask

  task automatic doReset();
    reset = 1'b1;
    sb_q.delete();
    gs_q.delete();
    sb3_q.delete();
    @(negedge clk);
    checkOutput("rst_data_out", data_out, 32'd0);
    checkOutput("rst_write_enable", 32'(write_enable), 32'd0);
    checkOutput("rst_game_start", 32'(game_start), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_round_count", 32'(round_count), 32'd0);
    reset = 1'b0;
  endtask

  task automatic endRound();
    game_end = 1'b1;
    @(negedge clk);
    game_end = 1'b0;
  endtask

  task automatic seededRound(input logic [15:0] s, output logic [31:0] word);
    seed_load = 1'b1;
    seed = s;
    @(negedge clk);
    seed_load = 1'b0;
    repeat (3) @(negedge clk);
    applyStimulus(1'b0);
    waitFor(0, 1000, "timeout_we_seeded");
    word = data_out;
    waitFor(1, 50, "timeout_gs_seeded");
    @(negedge clk);
    endRound();
  endtask

  // Strobe monitor: pops the scoreboard on every write_enable / game_start.
  initial begin
    exp_t       e;
    logic [2:0] f;
    bit         bad;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (write_enable || game_start)
          checkOutput("strobe_overlap", 32'(write_enable && game_start), 32'd0);
        if (write_enable) begin
          we_count++;
          if (sb_q.size() == 0) begin
            checkOutput("unexpected_we", 32'd1, 32'd0);
          end else begin
            e = sb_q.pop_front();
            checkOutput("data_out", data_out, e.word);
            checkOutput("we_cycle", 32'(cyc), 32'(e.we_cyc));
            checkOutput("we_latency_min",
                        32'((cyc - e.drive_cyc) >= NOTE_COUNT + 1), 32'd1);
            bad = 1'b0;
            for (int i = 0; i < 8; i++) begin
              f = data_out[4*i +: 3];
              if (data_out[4*i+3] || f == 3'd0) bad = 1'b1;
              if (i > 0 && f == data_out[4*(i-1) +: 3]) bad = 1'b1;
            end
            checkOutput("fields_valid", 32'(bad), 32'd0);
            gs_q.push_back(cyc + START_DELAY + 1);
          end
        end
        if (game_start) begin
          gs_count++;
          if (gs_q.size() == 0) begin
            checkOutput("unexpected_gs", 32'd1, 32'd0);
          end else begin
            checkOutput("gs_cycle", 32'(cyc), 32'(gs_q.pop_front()));
            checkOutput("gs_busy", 32'(busy), 32'd1);
          end
        end
        if (game_start3) gs3_count++;
        if (write_enable3) begin
          if (sb3_q.size() == 0) begin
            checkOutput("unexpected_we3", 32'd1, 32'd0);
          end else begin
            e = sb3_q.pop_front();
            checkOutput("data_out3", data_out3, e.word);
            checkOutput("data_out3_upper", {12'd0, data_out3[31:12]}, 32'd0);
            checkOutput("we3_cycle", 32'(cyc), 32'(e.we_cyc));
            checkOutput("we3_latency_min", 32'((cyc - e.drive_cyc) >= 4), 32'd1);
          end
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] word_a;
    logic [31:0] word_b;
    int          we_before;
    int          gs_before;

    repeat (2) @(negedge clk);
    doReset();

    // Plain round: one pulse, wait for start, then finish the round.
    applyStimulus(1'b0);
    waitFor(1, 1000, "timeout_gs_basic");
    @(negedge clk);
    checkOutput("busy_wait_end", 32'(busy), 32'd1);
    checkOutput("round_before_end", 32'(round_count), 32'd0);
    endRound();
    checkOutput("round_after_end", 32'(round_count), 32'd1);
    checkOutput("busy_after_end", 32'(busy), 32'd0);
    checkOutput("we_count_basic", 32'(we_count), 32'd1);
    checkOutput("gs_count_basic", 32'(gs_count), 32'd1);

    // Seeded rounds are reproducible; seed 0 maps onto seed 1.
    doReset();
    seededRound(16'h1234, word_a);
    doReset();
    seededRound(16'h1234, word_b);
    checkOutput("seed_repeat", word_a, word_b);
    doReset();
    seededRound(16'h0000, word_a);
    doReset();
    seededRound(16'h0001, word_b);
    checkOutput("seed_zero_eq_one", word_a, word_b);

    // new_game held high for the whole round must not queue a second one.
    doReset();
    we_before = we_count;
    gs_before = gs_count;
    applyStimulus(1'b1);
    repeat (80) @(negedge clk);
    checkOutput("held_we_count", 32'(we_count - we_before), 32'd1);
    checkOutput("held_gs_count", 32'(gs_count - gs_before), 32'd1);
    checkOutput("held_round_count", 32'(round_count), 32'd0);
    checkOutput("held_busy", 32'(busy), 32'd1);
    new_game = 1'b0;
    endRound();
    checkOutput("held_round_after", 32'(round_count), 32'd1);

    // Reset in the middle of GEN, then in the middle of DELAY.
    we_before = we_count;
    gs_before = gs_count;
    applyStimulus(1'b0);
    repeat (3) @(negedge clk);
    doReset();
    repeat (40) @(negedge clk);
    checkOutput("midgen_no_we", 32'(we_count - we_before), 32'd0);
    checkOutput("midgen_no_gs", 32'(gs_count - gs_before), 32'd0);
    applyStimulus(1'b0);
    waitFor(0, 1000, "timeout_we_middelay");
    repeat (2) @(negedge clk);
    gs_before = gs_count;
    doReset();
    repeat (40) @(negedge clk);
    checkOutput("middelay_no_gs", 32'(gs_count - gs_before), 32'd0);
    checkOutput("middelay_busy", 32'(busy), 32'd0);

    // game_end held high: each round ends on its first WAIT_END cycle.
    doReset();
    game_end = 1'b1;
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b0);
      waitFor(2, 1000, "timeout_round_end");
      if (i == 253) checkOutput("round_254", 32'(round_count), 32'd254);
      if (i == 254) checkOutput("round_255", 32'(round_count), 32'd255);
    end
    game_end = 1'b0;
    checkOutput("round_saturated", 32'(round_count), 32'd255);

    // Three-note build on the second instance.
    doReset();
    repeat (5) @(negedge clk);
    applyStimulus3();
    waitFor(3, 1000, "timeout_we3_a");
    repeat (20) @(negedge clk);
    applyStimulus3();
    waitFor(3, 1000, "timeout_we3_b");
    repeat (20) @(negedge clk);
    checkOutput("round_count3", 32'(round_count3), 32'd2);
    checkOutput("gs3_count", 32'(gs3_count), 32'd2);
    checkOutput("busy3_idle", 32'(busy3), 32'd0);

    repeat (5) @(negedge clk);
    checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);
    checkOutput("gs_q_empty", 32'(gs_q.size()), 32'd0);
    checkOutput("sb3_empty", 32'(sb3_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
